// File: rtl/world_pkg.sv
// Shared world-cell definitions: cell layout, block types, op codes, FSM states.
// Cell word: bit4 sugar, bit3 ant, bits[2:0] block type.
package world_pkg;

    localparam int CELL_W    = 5;
    localparam int TYPE_W    = 3;
    localparam int ANT_BIT   = 3;
    localparam int SUGAR_BIT = 4;

    typedef enum logic [2:0] {
        BLK_EMPTY      = 3'd0,
        BLK_AIR        = 3'd1,
        BLK_DIRT       = 3'd2,
        BLK_GROUND     = 3'd3,
        BLK_QUEEN      = 3'd4,
        BLK_WALL       = 3'd5,
        BLK_ERRORBLOCK = 3'd6,
        BLK_TUNNEL     = 3'd7
    } block_t;

    typedef enum logic [2:0] {
        OP_SET_TYPE  = 3'd0,
        OP_SET_ANT   = 3'd1,
        OP_CLR_ANT   = 3'd2,
        OP_SET_SUGAR = 3'd3,
        OP_CLR_SUGAR = 3'd4,
        OP_CLEAR     = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Op codes 6 and 7 are unassigned and must be rejected.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_CLEAR);
    endfunction

endpackage

// File: rtl/cell_merge.sv
// Combinational cell composer: applies one op to an old cell word and
// flags requests that would create an illegal cell.
module cell_merge
    import world_pkg::*;
(
    input  logic [CELL_W-1:0] i_old_cell,
    input  logic [2:0]        i_op,
    input  logic [TYPE_W-1:0] i_type,
    output logic [CELL_W-1:0] o_new_cell,
    output logic              o_reject
);

    logic [TYPE_W-1:0] w_old_type;
    logic              w_old_ant;

    assign w_old_type = i_old_cell[TYPE_W-1:0];
    assign w_old_ant  = i_old_cell[ANT_BIT];

    // Compose the new word and evaluate the legality rules for the op.
    always_comb begin
        // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
        o_new_cell = i_old_cell;
        o_reject   = 1'b0;
        case (i_op)
            OP_SET_TYPE: begin
                o_new_cell = {i_old_cell[CELL_W-1:ANT_BIT], i_type};
                if (i_type == BLK_ERRORBLOCK) begin
                    o_reject = 1'b1;
                end
                if (w_old_ant && (i_type == BLK_WALL || i_type == BLK_GROUND)) begin
                    o_reject = 1'b1;
                end
            end
            OP_SET_ANT: begin
                o_new_cell[ANT_BIT] = 1'b1;
                if (w_old_ant || w_old_type == BLK_WALL || w_old_type == BLK_GROUND ||
                    w_old_type == BLK_ERRORBLOCK) begin
                    o_reject = 1'b1;
                end
            end
            OP_CLR_ANT:   o_new_cell[ANT_BIT]   = 1'b0;
            OP_SET_SUGAR: o_new_cell[SUGAR_BIT] = 1'b1;
            OP_CLR_SUGAR: o_new_cell[SUGAR_BIT] = 1'b0;
            OP_CLEAR:     o_new_cell            = '0;
            default:      o_reject              = 1'b1;
        endcase
    end

endmodule

// File: rtl/cell_writer.sv
// Read-modify-write engine for 5-bit world cells in grid RAM.
// Serialises one request at a time: IDLE -> READ -> MERGE -> WRITE, or
// IDLE -> RESP for out-of-range coordinates and unassigned op codes.
// Optional build macro CELL_WRITER_STATS_EN adds saturating write/reject counters.
module cell_writer
    import world_pkg::*;
#(
    parameter int GRID_W = 64,
    parameter int GRID_H = 48,
    parameter int X_W    = 6,
    parameter int Y_W    = 6,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [X_W-1:0]    req_x,
    input  logic [Y_W-1:0]    req_y,
    input  logic [2:0]        req_op,
    input  logic [TYPE_W-1:0] req_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [CELL_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [CELL_W-1:0] mem_wdata,
    output logic              done,
    output logic              err,
    output logic [CELL_W-1:0] old_cell
`ifdef CELL_WRITER_STATS_EN
    ,
    output logic [15:0]       stat_writes,
    output logic [15:0]       stat_rejects
`endif
);

    state_t            r_state;
    logic [2:0]        r_op;
    logic [TYPE_W-1:0] r_type;

    logic [ADDR_W-1:0] w_addr;
    logic              w_bad_req;
    logic [CELL_W-1:0] w_new_cell;
    logic              w_reject;

    // Row-major address; out-of-range requests never reach memory, so wrap is harmless.
    assign w_addr    = ADDR_W'(req_y) * ADDR_W'(GRID_W) + ADDR_W'(req_x);
    assign w_bad_req = (int'(req_x) >= GRID_W) || (int'(req_y) >= GRID_H) || !op_is_legal(req_op);

    cell_merge u_merge (
        .i_old_cell (mem_rdata),
        .i_op       (r_op),
        .i_type     (r_type),
        .o_new_cell (w_new_cell),
        .o_reject   (w_reject)
    );

    // Request FSM; every output is registered and asserted while in its state.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_type    <= '0;
            req_ready <= 1'b1;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            old_cell  <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        mem_addr  <= w_addr;
                        r_op      <= req_op;
                        r_type    <= req_type;
                        req_ready <= 1'b0;
                        if (w_bad_req) begin
                            r_state <= S_RESP;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            r_state   <= S_READ;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_MERGE;
                end
                S_MERGE: begin
                    old_cell  <= mem_rdata;
                    mem_wdata <= w_new_cell;
                    mem_we    <= !w_reject;
                    done      <= 1'b1;
                    err       <= w_reject;
                    r_state   <= S_WRITE;
                end
                S_WRITE, S_RESP: begin
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CELL_WRITER_STATS_EN
    // Saturating counters of committed writes and rejected requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_writes  <= '0;
            stat_rejects <= '0;
        end else begin
            if (mem_we && stat_writes != 16'hFFFF) begin
                stat_writes <= stat_writes + 16'd1;
            end
            if (done && err && stat_rejects != 16'hFFFF) begin
                stat_rejects <= stat_rejects + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cell_writer.sv
// Directed self-checking bench for cell_writer with a behavioural grid RAM.
// X_W is widened to 7 so that the x=64 out-of-range case can be driven.
module tb_cell_writer;
    import world_pkg::*;

    localparam int XW = 7;
    localparam int YW = 6;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [XW-1:0] req_x = '0;
    logic [YW-1:0] req_y = '0;
    logic [2:0]    req_op = '0;
    logic [2:0]    req_type = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [4:0]    mem_rdata = '0;
    logic          mem_we;
    logic [4:0]    mem_wdata;
    logic          done;
    logic          err;
    logic [4:0]    old_cell;
`ifdef CELL_WRITER_STATS_EN
    logic [15:0]   stat_writes;
    logic [15:0]   stat_rejects;
`endif

    logic [4:0]    ram [0:4095];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [4:0]    pl_data = '0;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int we_cnt = 0;
    int both_cnt = 0;

    int         lat, rd_n, we_n, w0;
    logic [4:0] wd, old;
    logic       e, wed, rdy;

    always #5 clk = ~clk;

    cell_writer #(.GRID_W(64), .GRID_H(48), .X_W(XW), .Y_W(YW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_op    (req_op),
        .req_type  (req_type),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err),
        .old_cell  (old_cell)
`ifdef CELL_WRITER_STATS_EN
        ,
        .stat_writes  (stat_writes),
        .stat_rejects (stat_rejects)
`endif
    );

    // Grid RAM: one-cycle read latency, bench preload port has priority.
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    // Strobe monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rd_en) rd_cnt++;
        if (mem_we) we_cnt++;
        if (mem_rd_en && mem_we) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [4:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Issue one request from idle, wait (bounded) for done, then one more cycle.
    task automatic do_req(input logic [XW-1:0] x, input logic [YW-1:0] y,
                          input logic [2:0] op, input logic [2:0] typ,
                          output int o_lat, output logic [4:0] o_wd, output logic [4:0] o_old,
                          output logic o_e, output logic o_we, output int o_rd_n,
                          output int o_we_n, output logic o_rdy);
        int r0, wc0;
        r0 = rd_cnt;
        wc0 = we_cnt;
        req_x = x; req_y = y; req_op = op; req_type = typ; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        o_lat = 1;
        while (!done && o_lat < 10) begin
            @(posedge clk); #1;
            o_lat++;
        end
        o_wd = mem_wdata; o_old = old_cell; o_e = err; o_we = mem_we;
        @(posedge clk); #1;
        o_rdy = req_ready;
        o_rd_n = rd_cnt - r0;
        o_we_n = we_cnt - wc0;
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", 32'(req_ready), 1);
        check("rst_done",  32'(done), 0);
        check("rst_err",   32'(err), 0);
        check("rst_we",    32'(mem_we), 0);
        check("rst_rd_en", 32'(mem_rd_en), 0);
        check("rst_addr",  32'(mem_addr), 0);
        check("rst_old",   32'(old_cell), 0);
        check("rst_wdata", 32'(mem_wdata), 0);

        // SET_TYPE dirt at (3,2), cycle-by-cycle
        preload(12'd131, 5'b00001);
        req_x = 3; req_y = 2; req_op = OP_SET_TYPE; req_type = BLK_DIRT; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("st_c1_ready", 32'(req_ready), 0);
        check("st_c1_rd_en", 32'(mem_rd_en), 1);
        check("st_c1_addr",  32'(mem_addr), 131);
        @(posedge clk); #1;
        check("st_c2_rd_en", 32'(mem_rd_en), 0);
        check("st_c2_done",  32'(done), 0);
        @(posedge clk); #1;
        check("st_c3_done",  32'(done), 1);
        check("st_c3_err",   32'(err), 0);
        check("st_c3_we",    32'(mem_we), 1);
        check("st_c3_rd_en", 32'(mem_rd_en), 0);
        check("st_c3_wdata", 32'(mem_wdata), 5'b00010);
        check("st_c3_old",   32'(old_cell), 5'b00001);
        check("st_c3_addr",  32'(mem_addr), 131);
        @(posedge clk); #1;
        check("st_c4_ready", 32'(req_ready), 1);
        check("st_c4_done",  32'(done), 0);
        check("st_ram",      32'(ram[131]), 5'b00010);

        // SET_ANT onto ant-on-tunnel: collision
        preload(12'd330, 5'b01111);
        do_req(10, 5, OP_SET_ANT, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("ant_col_lat", 32'(lat), 3);
        check("ant_col_err", 32'(e), 1);
        check("ant_col_we",  32'(we_n), 0);
        check("ant_col_ram", 32'(ram[330]), 5'b01111);

        // SET_SUGAR at the far corner
        preload(12'd3071, 5'b00111);
        do_req(63, 47, OP_SET_SUGAR, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("corner_lat",   32'(lat), 3);
        check("corner_err",   32'(e), 0);
        check("corner_wdata", 32'(wd), 5'b10111);
        check("corner_addr",  32'(mem_addr), 3071);
        check("corner_ram",   32'(ram[3071]), 5'b10111);
        check("corner_rdy",   32'(rdy), 1);

        // x out of range
        do_req(64, 0, OP_SET_SUGAR, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("x64_lat", 32'(lat), 1);
        check("x64_err", 32'(e), 1);
        check("x64_rd",  32'(rd_n), 0);
        check("x64_we",  32'(we_n), 0);
        check("x64_rdy", 32'(rdy), 1);

        // y out of range
        do_req(0, 48, OP_CLEAR, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("y48_lat", 32'(lat), 1);
        check("y48_err", 32'(e), 1);
        check("y48_rd",  32'(rd_n), 0);

        // Unassigned op code
        do_req(1, 1, 3'd6, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("op6_lat", 32'(lat), 1);
        check("op6_err", 32'(e), 1);
        check("op6_rd",  32'(rd_n), 0);

        // SET_TYPE errorblock is always rejected
        preload(12'd325, 5'b00010);
        do_req(5, 5, OP_SET_TYPE, BLK_ERRORBLOCK, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("eb_err", 32'(e), 1);
        check("eb_we",  32'(we_n), 0);
        check("eb_ram", 32'(ram[325]), 5'b00010);

        // SET_TYPE wall while an ant stands on the cell
        preload(12'd390, 5'b01010);
        do_req(6, 6, OP_SET_TYPE, BLK_WALL, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("wall_ant_err", 32'(e), 1);
        check("wall_ant_we",  32'(we_n), 0);

        // CLR_SUGAR on a cell without sugar: legal, unchanged rewrite
        preload(12'd455, 5'b00011);
        do_req(7, 7, OP_CLR_SUGAR, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("clrs_err",   32'(e), 0);
        check("clrs_we",    32'(wed), 1);
        check("clrs_wdata", 32'(wd), 5'b00011);
        check("clrs_old",   32'(old), 5'b00011);

        // CLEAR
        preload(12'd520, 5'b11111);
        do_req(8, 8, OP_CLEAR, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("clr_wdata", 32'(wd), 5'b00000);
        check("clr_old",   32'(old), 5'b11111);
        check("clr_ram",   32'(ram[520]), 5'b00000);

        // SET_ANT on air: legal
        preload(12'd585, 5'b00001);
        do_req(9, 9, OP_SET_ANT, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("ant_air_err",   32'(e), 0);
        check("ant_air_wdata", 32'(wd), 5'b01001);
        check("ant_air_rd",    32'(rd_n), 1);
        check("ant_air_we",    32'(we_n), 1);

        // CLR_ANT clears only the ant bit
        preload(12'd650, 5'b11010);
        do_req(10, 10, OP_CLR_ANT, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("clra_err",   32'(e), 0);
        check("clra_wdata", 32'(wd), 5'b10010);

        // Back-to-back with req_valid held
        preload(12'd0, 5'b00010);
        preload(12'd1, 5'b00000);
        req_x = 0; req_y = 0; req_op = OP_SET_ANT; req_type = 0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_x = 1; req_op = OP_SET_SUGAR;
        check("b2b_c1_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        check("b2b_c2_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        check("b2b_c3_ready", 32'(req_ready), 0);
        check("b2b_c3_done",  32'(done), 1);
        check("b2b_c3_wdata", 32'(mem_wdata), 5'b01010);
        @(posedge clk); #1;
        check("b2b_c4_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_c5_ready", 32'(req_ready), 0);
        check("b2b_c5_rd_en", 32'(mem_rd_en), 1);
        check("b2b_c5_addr",  32'(mem_addr), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b2b_c7_done",  32'(done), 1);
        check("b2b_c7_wdata", 32'(mem_wdata), 5'b10000);
        @(posedge clk); #1;
        check("b2b_ram0", 32'(ram[0]), 5'b01010);
        check("b2b_ram1", 32'(ram[1]), 5'b10000);

        // Reset asserted during MERGE drops the write and the done pulse
        preload(12'd130, 5'b00000);
        w0 = we_cnt;
        req_x = 2; req_y = 2; req_op = OP_SET_TYPE; req_type = BLK_DIRT; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rmid_done",  32'(done), 0);
        check("rmid_we",    32'(mem_we), 0);
        check("rmid_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        check("rmid_done2",  32'(done), 0);
        check("rmid_ready2", 32'(req_ready), 1);
        check("rmid_we_cnt", 32'(we_cnt - w0), 0);
        check("rmid_ram",    32'(ram[130]), 5'b00000);

`ifdef CELL_WRITER_STATS_EN
        // Counters: 3 writes + 2 rejects, then saturation
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("stat_rst_w", 32'(stat_writes), 0);
        preload(12'd200, 5'b00000);
        repeat (3) do_req(8, 3, OP_SET_SUGAR, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        repeat (2) do_req(8, 3, 3'd7, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("stat_writes",  32'(stat_writes), 3);
        check("stat_rejects", 32'(stat_rejects), 2);
        force dut.stat_writes = 16'hFFFF;
        @(posedge clk); #1;
        release dut.stat_writes;
        do_req(8, 3, OP_SET_SUGAR, 0, lat, wd, old, e, wed, rd_n, we_n, rdy);
        check("stat_sat_we", 32'(we_n), 1);
        check("stat_sat",    32'(stat_writes), 16'hFFFF);
`endif

        check("rd_we_overlap", 32'(both_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
